decade_2421_display: RTL

Downstream consumer of the 2421-code decade counter. Samples the 4-bit 2421 code on each valid strobe and converts it to BCD. Flags illegal codes and out-of-sequence steps. Counts decade rollovers into a 3-digit BCD tally and drives a time-multiplexed 4-digit active-low seven-segment display (digit 0 = current decade digit, digits 1..3 = rollover count).

---
 rtl/decade_2421_display.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/decade_2421_display.sv
// decade_2421_display
// Samples a 2421-coded decade digit on each valid strobe and decodes it to BCD.
// Flags illegal codes and out-of-sequence steps, tallies decade rollovers as
// a 3-digit BCD count, and scans a 4-digit active-low seven-segment display.

module decade_2421_display #(
   parameter int SCAN_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  code_in,
   input  logic        code_valid,
   output logic [3:0]  bcd_out,
   output logic [11:0] wrap_cnt,
   output logic        code_err,
   output logic        seq_err,
   output logic [6:0]  seg_n,
   output logic [3:0]  an_n
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [6:0] SEG_E   = 7'b0000110;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   logic [3:0]       dec_val;
   logic             dec_legal;
   logic [3:0]       prev;
   logic             has_prev;
   logic [3:0]       succ_prev;
   logic [11:0]      wrap_next;
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       scan_idx;
   logic [3:0]       digit_sel;
   logic             show_e;
   logic [6:0]       seg_next;
   logic [3:0]       an_next;

   // Active-low segment pattern (g..a) for a BCD digit; non-digits are blanked.
   function automatic logic [6:0] seg_pattern(input logic [3:0] d);
      case (d)
         4'd0:    seg_pattern = 7'b1000000;
         4'd1:    seg_pattern = 7'b1111001;
         4'd2:    seg_pattern = 7'b0100100;
         4'd3:    seg_pattern = 7'b0110000;
         4'd4:    seg_pattern = 7'b0011001;
         4'd5:    seg_pattern = 7'b0010010;
         4'd6:    seg_pattern = 7'b0000010;
         4'd7:    seg_pattern = 7'b1111000;
         4'd8:    seg_pattern = 7'b0000000;
         4'd9:    seg_pattern = 7'b0010000;
         default: seg_pattern = SEG_OFF;
      endcase
   endfunction

   // Decode the 2421 code; the six codes outside the table are illegal.
   always_comb begin
      dec_val   = 4'd0;
      dec_legal = 1'b1;
      case (code_in)
         4'b0000, 4'b0001, 4'b0010,
         4'b0011, 4'b0100: dec_val = code_in;
         4'b1011:          dec_val = 4'd5;
         4'b1100:          dec_val = 4'd6;
         4'b1101:          dec_val = 4'd7;
         4'b1110:          dec_val = 4'd8;
         4'b1111:          dec_val = 4'd9;
         default:          dec_legal = 1'b0;
      endcase
   end

   // Expected successor of the last legal digit, wrapping 9 back to 0.
   always_comb begin
      succ_prev = (prev == 4'd9) ? 4'd0 : prev + 4'd1;
   end

   // Three-digit BCD increment of the rollover tally; 999 wraps to 000.
   always_comb begin
      wrap_next = wrap_cnt;
      if (wrap_cnt[3:0] != 4'd9) begin
         wrap_next[3:0] = wrap_cnt[3:0] + 4'd1;
      end else begin
         wrap_next[3:0] = 4'd0;
         if (wrap_cnt[7:4] != 4'd9) begin
            wrap_next[7:4] = wrap_cnt[7:4] + 4'd1;
         end else begin
            wrap_next[7:4]  = 4'd0;
            wrap_next[11:8] = (wrap_cnt[11:8] == 4'd9) ? 4'd0 : wrap_cnt[11:8] + 4'd1;
         end
      end
   end

   // Sample path: legal codes update the digit, sequence check and tally;
   // illegal codes only raise the sticky code error.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_out  <= 4'd0;
         wrap_cnt <= 12'h000;
         code_err <= 1'b0;
         seq_err  <= 1'b0;
         prev     <= 4'd0;
         has_prev <= 1'b0;
      end else if (code_valid) begin
         if (dec_legal) begin
            bcd_out  <= dec_val;
            prev     <= dec_val;
            has_prev <= 1'b1;
            if (has_prev && (dec_val != succ_prev)) begin
               seq_err <= 1'b1;
            end
            if (has_prev && (prev == 4'd9) && (dec_val == 4'd0)) begin
               wrap_cnt <= wrap_next;
            end
         end else begin
            code_err <= 1'b1;
         end
      end
   end

   // Scan timing: each digit stays selected for SCAN_DIV cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         scan_idx <= 2'd0;
      end else if (scan_cnt == CNT_LAST) begin
         scan_cnt <= '0;
         scan_idx <= scan_idx + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Pick the digit and anode for the slot currently being scanned.
   always_comb begin
      an_next   = 4'b1110;
      digit_sel = bcd_out;
      show_e    = 1'b0;
      case (scan_idx)
         2'd0: begin
            an_next   = 4'b1110;
            digit_sel = bcd_out;
            show_e    = code_err;
         end
         2'd1: begin
            an_next   = 4'b1101;
            digit_sel = wrap_cnt[3:0];
         end
         2'd2: begin
            an_next   = 4'b1011;
            digit_sel = wrap_cnt[7:4];
         end
         default: begin
            an_next   = 4'b0111;
            digit_sel = wrap_cnt[11:8];
         end
      endcase
      seg_next = show_e ? SEG_E : seg_pattern(digit_sel);
   end

   // Register the display drive so the pins are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_n  <= 4'b1110;
         seg_n <= 7'b1000000;
      end else begin
         an_n  <= an_next;
         seg_n <= seg_next;
      end
   end

endmodule
